// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmit and receive paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int DEF_DATA_WIDTH = 8;

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period timer for the UART transmitter.
// Produces a strobe in the last clock of each bit and tracks the data bit index.
module tx_bit_timer #(
    parameter int PRESCALE_WIDTH = 6,
    parameter int BIT_W          = 3,
    parameter int LAST_BIT       = 7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      run_i,
    input  logic                      clr_i,
    input  logic                      bit_adv_i,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    output logic                      bit_done_o,
    output logic [BIT_W-1:0]          bit_idx_o
);

    logic [PRESCALE_WIDTH-1:0] cyc_q, cyc_d;
    logic [BIT_W-1:0]          bit_q, bit_d;
    logic [PRESCALE_WIDTH-1:0] last_cyc;

    // A prescale of zero behaves as one clock per bit
    assign last_cyc   = (prescale_i == '0) ? '0
                      : prescale_i - PRESCALE_WIDTH'(1);
    assign bit_done_o = run_i && (cyc_q == last_cyc);
    assign bit_idx_o  = bit_q;

    always_comb begin
        cyc_d = cyc_q;
        bit_d = bit_q;
        if (clr_i) begin
            cyc_d = '0;
            bit_d = '0;
        end else if (run_i) begin
            if (bit_done_o) begin
                cyc_d = '0;
                if (bit_adv_i) begin
                    bit_d = (bit_q == BIT_W'(LAST_BIT)) ? '0
                          : bit_q + BIT_W'(1);
                end
            end else begin
                cyc_d = cyc_q + PRESCALE_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q <= '0;
            bit_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            bit_q <= bit_d;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: one byte per request as start/data/parity/stop frame.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 6,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      Data_Valid,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    output logic                      TX_OUT,
    output logic                      Busy
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    tx_state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic                      par_en_q, par_en_d;
    logic                      par_q, par_d;
    logic [PRESCALE_WIDTH-1:0] pre_q, pre_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;

    logic                      accept;
    logic                      bit_done;
    logic [BIT_W-1:0]          bit_idx;

    // Registered Busy gates the request, so a frame can't restart on the
    // same edge that ends the previous one
    assign accept = Data_Valid && !busy_q;

    tx_bit_timer #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH),
        .BIT_W         (BIT_W),
        .LAST_BIT      (DATA_WIDTH - 1)
    ) u_timer (
        .clk       (CLK),
        .rst_n     (RST),
        .run_i     (state_q != IDLE),
        .clr_i     (accept),
        .bit_adv_i (state_q == DATA),
        .prescale_i(pre_q),
        .bit_done_o(bit_done),
        .bit_idx_o (bit_idx)
    );

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        par_en_d = par_en_q;
        par_d    = par_q;
        pre_d    = pre_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (accept) begin
                    data_d   = P_DATA;
                    par_en_d = PAR_EN;
                    par_d    = (^P_DATA) ^ PAR_TYP;
                    pre_d    = Prescale;
                    state_d  = START;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                    tx_d    = data_q[0];
                    data_d  = data_q >> 1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_idx == BIT_W'(DATA_WIDTH - 1)) begin
                        state_d = par_en_q ? PARITY : STOP;
                        tx_d    = par_en_q ? par_q : 1'b1;
                    end else begin
                        tx_d   = data_q[0];
                        data_d = data_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            data_q   <= '0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            pre_q    <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            par_en_q <= par_en_d;
            par_q    <= par_d;
            pre_q    <= pre_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
        end
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: frame tables plus loopback and reset sequences.
module tb_uart_tx_frame;
    import uart_pkg::*;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [5:0] Prescale = '0;
    logic [7:0] P_DATA = '0;
    logic       Data_Valid = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       TX_OUT;
    logic       Busy;

    uart_tx_frame #(.PRESCALE_WIDTH(6), .DATA_WIDTH(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .Prescale  (Prescale),
        .P_DATA    (P_DATA),
        .Data_Valid(Data_Valid),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .TX_OUT    (TX_OUT),
        .Busy      (Busy)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       name;
        logic [5:0]  pre;
        logic [7:0]  data;
        logic        pen;
        logic        ptyp;
        logic        poke;
        int          nbits;
        logic [10:0] bits;   // bits[0] is the first bit on the line
        int          len;
    } vec_t;

    vec_t vt[5];
    logic line[0:511];
    logic bsy[0:511];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int   c;
        int   p;
        int   idx;
        logic got;
        @(negedge CLK);
        Prescale   = v.pre;
        P_DATA     = v.data;
        PAR_EN     = v.pen;
        PAR_TYP    = v.ptyp;
        Data_Valid = 1'b1;
        @(posedge CLK);
        #1;
        Data_Valid = 1'b0;
        chk({v.name, " accept busy/tx"}, {30'd0, Busy, TX_OUT}, 32'd2);
        c = 0;
        while (Busy && c < 500) begin
            line[c] = TX_OUT;
            if (v.poke && c == 20) begin
                P_DATA     = 8'h11;
                PAR_TYP    = ~v.ptyp;
                Prescale   = 6'd3;
                Data_Valid = 1'b1;
            end
            if (v.poke && c == 21) Data_Valid = 1'b0;
            @(posedge CLK);
            #1;
            c++;
        end
        chk({v.name, " busy length"}, c, v.len);
        p = (v.pre == 0) ? 1 : int'(v.pre);
        for (int b = 0; b < v.nbits; b++) begin
            got = v.bits[b];
            for (int j = 0; j < p; j++) begin
                idx = b * p + j;
                if (idx >= c) got = ~v.bits[b];
                else if (line[idx] !== v.bits[b]) got = line[idx];
            end
            chk($sformatf("%s bit%0d", v.name, b), {31'd0, got},
                {31'd0, v.bits[b]});
        end
        chk({v.name, " idle after"}, {30'd0, Busy, TX_OUT}, 32'd1);
        repeat (4) @(posedge CLK);
        #1;
        chk({v.name, " no extra frame"}, {30'd0, Busy, TX_OUT}, 32'd1);
    endtask

    // Independent receiver model sampling mid-bit from the captured line
    task automatic rx_decode(input int base, input int p, input logic ptyp,
                             output logic [7:0] d, output logic perr,
                             output logic serr, output logic sterr);
        logic pb;
        serr = line[base + p / 2] !== 1'b0;
        for (int b = 0; b < 8; b++) d[b] = line[base + (b + 1) * p + p / 2];
        pb    = line[base + 9 * p + p / 2];
        perr  = ((^d) ^ ptyp) !== pb;
        sterr = line[base + 10 * p + p / 2] !== 1'b1;
    endtask

    initial begin
        logic [7:0] d;
        logic       perr, serr, sterr;

        vt[0] = '{"even_A5", 6'd8, 8'hA5, 1'b1, PAR_EVEN, 1'b0, 11,
                  11'b10101001010, 88};
        vt[1] = '{"odd_A5_poked", 6'd8, 8'hA5, 1'b1, PAR_ODD, 1'b1, 11,
                  11'b11101001010, 88};
        vt[2] = '{"nopar_00", 6'd16, 8'h00, 1'b0, PAR_EVEN, 1'b0, 10,
                  11'b01000000000, 160};
        vt[3] = '{"even_3C_p3", 6'd3, 8'h3C, 1'b1, PAR_EVEN, 1'b0, 11,
                  11'b10001111000, 33};
        vt[4] = '{"odd_01_p0", 6'd0, 8'h01, 1'b1, PAR_ODD, 1'b0, 11,
                  11'b10000000010, 11};

        repeat (3) @(posedge CLK);
        #1;
        chk("reset busy/tx", {30'd0, Busy, TX_OUT}, 32'd1);
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("post-reset idle", {30'd0, Busy, TX_OUT}, 32'd1);

        for (int i = 0; i < 5; i++) run_vec(vt[i]);

        // Loopback: two frames back-to-back with Data_Valid held high
        @(negedge CLK);
        Prescale   = 6'd4;
        PAR_EN     = 1'b1;
        PAR_TYP    = PAR_ODD;
        P_DATA     = 8'h3C;
        Data_Valid = 1'b1;
        @(posedge CLK);
        #1;
        P_DATA = 8'hFF;
        for (int c = 0; c < 92; c++) begin
            line[c] = TX_OUT;
            bsy[c]  = Busy;
            if (c == 45) Data_Valid = 1'b0;
            @(posedge CLK);
            #1;
        end
        chk("lb busy end frame1", {31'd0, bsy[43]}, 32'd1);
        chk("lb gap busy low", {30'd0, bsy[44], line[44]}, 32'd1);
        chk("lb frame2 start", {30'd0, bsy[45], line[45]}, 32'd2);
        rx_decode(0, 4, PAR_ODD, d, perr, serr, sterr);
        chk("lb rx byte1", {24'd0, d}, 32'h3C);
        chk("lb rx err1", {29'd0, perr, serr, sterr}, 32'd0);
        rx_decode(45, 4, PAR_ODD, d, perr, serr, sterr);
        chk("lb rx byte2", {24'd0, d}, 32'hFF);
        chk("lb rx err2", {29'd0, perr, serr, sterr}, 32'd0);
        chk("lb end idle", {30'd0, bsy[89], line[89]}, 32'd1);
        chk("lb no third", {30'd0, bsy[91], line[91]}, 32'd1);

        // Reset during DATA aborts the frame at once
        @(negedge CLK);
        Prescale   = 6'd4;
        PAR_EN     = 1'b0;
        P_DATA     = 8'h00;
        Data_Valid = 1'b1;
        @(posedge CLK);
        #1;
        Data_Valid = 1'b0;
        repeat (14) @(posedge CLK);
        #1;
        chk("rst pre data low", {30'd0, Busy, TX_OUT}, 32'd2);
        RST = 1'b0;
        #1;
        chk("rst abort", {30'd0, Busy, TX_OUT}, 32'd1);
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst release idle", {30'd0, Busy, TX_OUT}, 32'd1);
        run_vec(vt[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
